// File: rtl/c499_sec_pkg.sv
// Shared constants, skid-buffer state type and check-bit helper for the c499 (32,8) SEC encoder.
package c499_sec_pkg;

    localparam int CODE_W = 40;
    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;

    localparam logic [DATA_W-1:0] CHK0_MASK = 32'h00FF1111;
    localparam logic [DATA_W-1:0] CHK1_MASK = 32'hFF002222;
    localparam logic [DATA_W-1:0] CHK2_MASK = 32'h0F0F4444;
    localparam logic [DATA_W-1:0] CHK3_MASK = 32'hF0F08888;
    localparam logic [DATA_W-1:0] CHK4_MASK = 32'h111100FF;
    localparam logic [DATA_W-1:0] CHK5_MASK = 32'h2222FF00;
    localparam logic [DATA_W-1:0] CHK6_MASK = 32'h44440F0F;
    localparam logic [DATA_W-1:0] CHK7_MASK = 32'h8888F0F0;

    localparam logic [CHK_W-1:0][DATA_W-1:0] CHK_MASK = {
        CHK7_MASK, CHK6_MASK, CHK5_MASK, CHK4_MASK,
        CHK3_MASK, CHK2_MASK, CHK1_MASK, CHK0_MASK
    };

    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_ONE   = 2'd1,
        SB_TWO   = 2'd2
    } skid_state_e;

    // Each check bit is the parity of the data bits selected by its mask.
    function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        for (int j = 0; j < CHK_W; j++) begin
            chk[j] = ^(data & CHK_MASK[j]);
        end
        return chk;
    endfunction

endpackage

// File: rtl/c499_skid_buf.sv
// Two-entry valid/ready buffer: main register drives the output, skid register absorbs
// one extra word so in_ready can be fully registered.
module c499_skid_buf
    import c499_sec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CODE_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CODE_W-1:0] out_data_o
);

    skid_state_e       state_q, state_d;
    logic [CODE_W-1:0] main_q, main_d;
    logic [CODE_W-1:0] skid_q, skid_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              accept;
    logic              pop;

    assign accept = in_valid_i && in_ready_q;
    assign pop    = out_valid_q && out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SB_EMPTY: begin
                if (accept) begin
                    main_d  = in_data_i;
                    state_d = SB_ONE;
                end
            end
            SB_ONE: begin
                if (accept && pop) begin
                    main_d = in_data_i;
                end else if (accept) begin
                    skid_d  = in_data_i;
                    state_d = SB_TWO;
                end else if (pop) begin
                    state_d = SB_EMPTY;
                end
            end
            SB_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    main_d  = skid_q;
                    state_d = SB_ONE;
                end
            end
            default: state_d = SB_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SB_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != SB_TWO);
            out_valid_q <= (state_d != SB_EMPTY);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/c499_sec_encoder.sv
// Streaming (32,8) SEC encoder for the c499 corrector, with optional one-shot or
// sticky XOR error injection and a saturating accepted-word counter.
module c499_sec_encoder
    import c499_sec_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    input  logic              inj_load,
    input  logic [CODE_W-1:0] inj_mask,
    input  logic              inj_sticky,
    output logic              inj_pending,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [CODE_W-1:0] mask_q;
    logic              sticky_q;
    logic              pending_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic [CODE_W-1:0] code_raw;
    logic [CODE_W-1:0] code_inj;

    assign accept   = in_valid && in_ready;
    assign code_raw = {calc_chk(in_data), in_data};
    // The word accepted now always sees the previously armed mask, even if inj_load is high.
    assign code_inj = pending_q ? (code_raw ^ mask_q) : code_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q    <= '0;
            sticky_q  <= 1'b0;
            pending_q <= 1'b0;
        end else if (inj_load) begin
            mask_q    <= inj_mask;
            sticky_q  <= inj_sticky;
            pending_q <= 1'b1;
        end else if (accept && !sticky_q) begin
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    c499_skid_buf u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (code_inj),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_code)
    );

    assign inj_pending = pending_q;
    assign word_cnt    = cnt_q;

endmodule
